// File: rtl/csa_stream_accumulator.sv
// Streaming 128-bit accumulator built on an internal carry-select adder; sticky overflow and
// saturating beat count. Define SATURATE_EN to clamp the sum to all-ones once a group overflows.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iClear,
  input  logic [WIDTH-1:0] iOperand,
  input  logic             iCarryIn,
  input  logic             iLast,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oOverflow,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  input  logic             iReady
);

  localparam int unsigned BlkW   = 8;
  localparam int unsigned NumBlk = WIDTH / BlkW;

  if (WIDTH != 128) begin : g_width_chk
    $error("csa_stream_accumulator supports WIDTH=128 only");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;

  logic [WIDTH-1:0]           add_a;
  logic [WIDTH-1:0]           add_sum;
  logic                       add_cout;
  logic [NumBlk-1:0][BlkW:0]  sum0;
  logic [NumBlk-1:0][BlkW:0]  sum1;
  logic                       beat;
  logic [CNT_W-1:0]           cnt_inc;

  // The first beat of a group starts from zero rather than the stale accumulator.
  assign add_a = (state_q == StIdle) ? '0 : acc_q;

  // Each block precomputes its sum for both possible carry-ins; the chain only selects.
  for (genvar g = 0; g < NumBlk; g++) begin : g_blk
    assign sum0[g] = {1'b0, add_a[g*BlkW +: BlkW]} + {1'b0, iOperand[g*BlkW +: BlkW]};
    assign sum1[g] = {1'b0, add_a[g*BlkW +: BlkW]} + {1'b0, iOperand[g*BlkW +: BlkW]}
                     + (BlkW+1)'(1);
  end

  always_comb begin
    logic c;
    c       = iCarryIn;
    add_sum = '0;
    for (int i = 0; i < NumBlk; i++) begin
      add_sum[i*BlkW +: BlkW] = c ? sum1[i][BlkW-1:0] : sum0[i][BlkW-1:0];
      c = c ? sum1[i][BlkW] : sum0[i][BlkW];
    end
    add_cout = c;
  end

  assign beat    = iValid & oReady;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (iClear) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (beat) begin
            acc_q <= add_sum;
            cnt_q <= CNT_W'(1);
            ovf_q <= 1'b0;
            if (iLast) begin
              state_q <= StDone;
              valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (beat) begin
`ifdef SATURATE_EN
            acc_q <= (ovf_q | add_cout) ? {WIDTH{1'b1}} : add_sum;
`else
            acc_q <= add_sum;
`endif
            ovf_q <= ovf_q | add_cout;
            cnt_q <= cnt_inc;
            if (iLast) begin
              state_q <= StDone;
              valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (iReady) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oReady    = (state_q != StDone);
  assign oResult   = acc_q;
  assign oOverflow = ovf_q;
  assign oCount    = cnt_q;
  assign oValid    = valid_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: a table of per-cycle vectors plus hand-written sequences
// for backpressure, abort, reset in DONE and count saturation.
module tb_csa_stream_accumulator;

  localparam logic [127:0] All1 = {128{1'b1}};

  logic         iClk = 1'b0;
  logic         iRstN;
  logic         iClear;
  logic [127:0] iOperand;
  logic         iCarryIn;
  logic         iLast;
  logic         iValid;
  logic         oReady;
  logic [127:0] oResult;
  logic         oOverflow;
  logic [7:0]   oCount;
  logic         oValid;
  logic         iReady;

  int n_tests = 0;
  int n_fail  = 0;

  csa_stream_accumulator #(.WIDTH(128), .CNT_W(8)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iClear    (iClear),
    .iOperand  (iOperand),
    .iCarryIn  (iCarryIn),
    .iLast     (iLast),
    .iValid    (iValid),
    .oReady    (oReady),
    .oResult   (oResult),
    .oOverflow (oOverflow),
    .oCount    (oCount),
    .oValid    (oValid),
    .iReady    (iReady)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic         vld;
    logic [127:0] op;
    logic         cin;
    logic         last;
    logic         rdy;
    logic         e_vld;
    logic         e_rdy;
    logic [127:0] e_res;
    logic [7:0]   e_cnt;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic vld, input logic [127:0] op, input logic cin,
                              input logic last, input logic rdy, input logic e_vld,
                              input logic e_rdy, input logic [127:0] e_res,
                              input logic [7:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.vld = vld; v.op = op; v.cin = cin; v.last = last; v.rdy = rdy;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_res = e_res; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_vld, input logic e_rdy,
                         input logic [127:0] e_res, input logic [7:0] e_cnt, input logic e_ovf);
    chk({tag, ".valid"},    128'(oValid),    128'(e_vld));
    chk({tag, ".ready"},    128'(oReady),    128'(e_rdy));
    chk({tag, ".result"},   oResult,         e_res);
    chk({tag, ".count"},    128'(oCount),    128'(e_cnt));
    chk({tag, ".overflow"}, 128'(oOverflow), 128'(e_ovf));
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic beat(input logic [127:0] op, input logic cin, input logic last);
    iValid = 1'b1; iOperand = op; iCarryIn = cin; iLast = last;
    step();
    iValid = 1'b0; iCarryIn = 1'b0; iLast = 1'b0;
  endtask

  logic [127:0] r_ovf0, r_ovf1;

  initial begin
`ifdef SATURATE_EN
    r_ovf0 = All1;
    r_ovf1 = All1;
`else
    r_ovf0 = 128'd0;
    r_ovf1 = 128'd5;
`endif
    //              vld op                cin last rdy   vld rdy result           cnt ovf
    vecs[0]  = mk(1, 128'd2245456,     1, 0, 0,    0, 1, 128'd2245457,     1, 0);
    vecs[1]  = mk(1, 128'd25643,       0, 0, 0,    0, 1, 128'd2271100,     2, 0);
    vecs[2]  = mk(0, 128'd0,           0, 0, 0,    0, 1, 128'd2271100,     2, 0);
    vecs[3]  = mk(1, 128'd2252131,     0, 1, 0,    1, 0, 128'd4523231,     3, 0);
    vecs[4]  = mk(0, 128'd0,           0, 0, 1,    0, 1, 128'd4523231,     3, 0);
    vecs[5]  = mk(1, 128'd22564654562, 0, 1, 0,    1, 0, 128'd22564654562, 1, 0);
    vecs[6]  = mk(0, 128'd0,           0, 0, 1,    0, 1, 128'd22564654562, 1, 0);
    vecs[7]  = mk(1, All1,             0, 0, 0,    0, 1, All1,             1, 0);
    vecs[8]  = mk(1, 128'd1,           0, 0, 0,    0, 1, r_ovf0,           2, 1);
    vecs[9]  = mk(1, 128'd5,           0, 1, 0,    1, 0, r_ovf1,           3, 1);
    vecs[10] = mk(0, 128'd0,           0, 0, 1,    0, 1, r_ovf1,           3, 1);
    vecs[11] = mk(1, 128'd0,           1, 0, 0,    0, 1, 128'd1,           1, 0);
    vecs[12] = mk(1, 128'd0,           0, 1, 0,    1, 0, 128'd1,           2, 0);
    vecs[13] = mk(0, 128'd0,           0, 0, 1,    0, 1, 128'd1,           2, 0);

    iRstN = 1'b0; iClear = 1'b0; iOperand = '0; iCarryIn = 1'b0; iLast = 1'b0;
    iValid = 1'b0; iReady = 1'b0;
    repeat (3) @(posedge iClk);
    #1 iRstN = 1'b1;
    step();
    chk_all("reset", 0, 1, 128'd0, 8'd0, 0);

    for (int i = 0; i < 14; i++) begin
      iValid = vecs[i].vld; iOperand = vecs[i].op; iCarryIn = vecs[i].cin;
      iLast = vecs[i].last; iReady = vecs[i].rdy;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_rdy, vecs[i].e_res,
              vecs[i].e_cnt, vecs[i].e_ovf);
    end
    iValid = 1'b0; iLast = 1'b0; iCarryIn = 1'b0; iReady = 1'b0;

    // Backpressure: DONE must ignore iValid until the sink takes the result.
    beat(128'd7, 1'b0, 1'b0);
    beat(128'd8, 1'b0, 1'b1);
    iValid = 1'b1; iOperand = 128'd100; iLast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("bp%0d", k), 1, 0, 128'd15, 8'd2, 0);
    end
    iValid = 1'b0; iLast = 1'b0; iReady = 1'b1;
    step();
    chk_all("bp_release", 0, 1, 128'd15, 8'd2, 0);
    iReady = 1'b0;

    // Abort in ACCUM: clear wins over a simultaneous beat.
    beat(128'd3, 1'b0, 1'b0);
    beat(128'd4, 1'b0, 1'b0);
    chk_all("pre_clr", 0, 1, 128'd7, 8'd2, 0);
    iValid = 1'b1; iOperand = 128'd9; iClear = 1'b1;
    step();
    iValid = 1'b0; iClear = 1'b0;
    chk_all("clr_accum", 0, 1, 128'd0, 8'd0, 0);

    // Abort in DONE with iReady also high.
    beat(All1, 1'b0, 1'b0);
    beat(128'd2, 1'b0, 1'b1);
    iClear = 1'b1; iReady = 1'b1;
    step();
    iClear = 1'b0; iReady = 1'b0;
    chk_all("clr_done", 0, 1, 128'd0, 8'd0, 0);

    // Asynchronous reset while in DONE.
    beat(128'd6, 1'b0, 1'b1);
    chk_all("pre_rst", 1, 0, 128'd6, 8'd1, 0);
    #2 iRstN = 1'b0;
    #1;
    chk_all("rst_done", 0, 1, 128'd0, 8'd0, 0);
    @(posedge iClk);
    #1 iRstN = 1'b1;

    // Count saturates at 255 over a 300-beat group.
    for (int k = 0; k < 300; k++) beat(128'd0, 1'b0, (k == 299));
    chk_all("cnt_sat", 1, 0, 128'd0, 8'd255, 0);
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    chk_all("cnt_sat_rel", 0, 1, 128'd0, 8'd255, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
